umi_host_arb: RTL and testbench

Round-robin arbiter that shares one UMI host request/response port pair among N requesters, such as several AXI4-Lite-to-UMI converters, or a converter plus a DMA engine. Each request carries the requester index, stamped into a reserved srcaddr field. Responses carry that field back in dstaddr and are steered to the matching requester. A per-requester outstanding counter throttles each requester to a bounded number of in-flight transactions.

---
 rtl/umi_host_arb.sv | 190 +++++++++++++++++++
 tb/tb_umi_host_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_host_arb.sv
// rtl/umi_host_arb.sv - round-robin UMI host port arbiter with tag-steered responses
// Stamps the requester index into srcaddr and routes responses back by the dstaddr tag.
module umi_host_arb #(
    parameter int N      = 2,
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 64,
    parameter int TAGLSB = 0,
    parameter int MAXOUT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_in_valid,
    input  logic [N*CW-1:0] req_in_cmd,
    input  logic [N*AW-1:0] req_in_dstaddr,
    input  logic [N*AW-1:0] req_in_srcaddr,
    input  logic [N*DW-1:0] req_in_data,
    output logic [N-1:0]    req_in_ready,
    output logic [N-1:0]    resp_out_valid,
    output logic [CW-1:0]   resp_out_cmd,
    output logic [AW-1:0]   resp_out_dstaddr,
    output logic [AW-1:0]   resp_out_srcaddr,
    output logic [DW-1:0]   resp_out_data,
    input  logic [N-1:0]    resp_out_ready,
    output logic            uhost_req_valid,
    output logic [CW-1:0]   uhost_req_cmd,
    output logic [AW-1:0]   uhost_req_dstaddr,
    output logic [AW-1:0]   uhost_req_srcaddr,
    output logic [DW-1:0]   uhost_req_data,
    input  logic            uhost_req_ready,
    input  logic            uhost_resp_valid,
    input  logic [CW-1:0]   uhost_resp_cmd,
    input  logic [AW-1:0]   uhost_resp_dstaddr,
    input  logic [AW-1:0]   uhost_resp_srcaddr,
    input  logic [DW-1:0]   uhost_resp_data,
    output logic            uhost_resp_ready,
    output logic            stray_resp
);
    localparam int TW = $clog2(N);
    localparam int EOM = 22;
    localparam logic [TW:0] NL = (TW+1)'(N);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [TW-1:0] gnt;
    logic [TW-1:0] rr_ptr;
    logic [7:0]    outcnt [N];

    logic [N-1:0]  elig;
    logic [N-1:0]  inc;
    logic [N-1:0]  dec;
    logic [N-1:0]  cnt_zero;
    logic          found;
    logic [TW-1:0] win;
    logic [TW:0]   cand;
    logic [TW-1:0] sel;
    logic          sel_act;
    logic [TW-1:0] next_ptr;
    logic          req_hs;
    logic          req_eom;
    logic [TW-1:0] tag;
    logic          tag_ok;
    logic          rdy_sel;
    logic          resp_hs;
    logic          dropped;
    logic          stray_next;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i]     = req_in_valid[i] && (outcnt[i] < 8'(MAXOUT));
            cnt_zero[i] = (outcnt[i] == 8'd0);
        end
    end

    // Cyclic search for the first eligible requester starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr} + (TW+1)'(k);
            if (cand >= NL)
                cand = cand - NL;
            if (!found && elig[cand[TW-1:0]]) begin
                found = 1'b1;
                win   = cand[TW-1:0];
            end
        end
    end

    assign sel      = (state == LOCK) ? gnt : win;
    assign sel_act  = !reset && ((state == LOCK) || found);
    assign next_ptr = (sel == TW'(N-1)) ? '0 : sel + 1'b1;

    always_comb begin
        uhost_req_valid   = 1'b0;
        uhost_req_cmd     = '0;
        uhost_req_dstaddr = '0;
        uhost_req_srcaddr = '0;
        uhost_req_data    = '0;
        req_in_ready      = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == TW'(i)) begin
                uhost_req_valid   = sel_act && req_in_valid[i];
                uhost_req_cmd     = req_in_cmd[i*CW +: CW];
                uhost_req_dstaddr = req_in_dstaddr[i*AW +: AW];
                uhost_req_srcaddr = req_in_srcaddr[i*AW +: AW];
                uhost_req_data    = req_in_data[i*DW +: DW];
                req_in_ready[i]   = sel_act && uhost_req_ready;
            end
        end
        uhost_req_srcaddr[TAGLSB +: TW] = sel;
    end

    assign req_hs  = uhost_req_valid && uhost_req_ready;
    assign req_eom = uhost_req_cmd[EOM];

    assign tag    = uhost_resp_dstaddr[TAGLSB +: TW];
    assign tag_ok = ({1'b0, tag} < NL);

    always_comb begin
        rdy_sel        = 1'b0;
        resp_out_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (tag == TW'(i)) begin
                rdy_sel           = resp_out_ready[i];
                resp_out_valid[i] = !reset && uhost_resp_valid;
            end
        end
    end

    // Beats whose tag names no requester are accepted and discarded.
    assign uhost_resp_ready = !reset && (tag_ok ? rdy_sel : 1'b1);
    assign resp_out_cmd     = uhost_resp_cmd;
    assign resp_out_dstaddr = uhost_resp_dstaddr;
    assign resp_out_srcaddr = uhost_resp_srcaddr;
    assign resp_out_data    = uhost_resp_data;

    assign resp_hs = uhost_resp_valid && uhost_resp_ready;
    assign dropped = resp_hs && !tag_ok;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            inc[i] = req_hs && req_eom && (sel == TW'(i));
            dec[i] = resp_hs && uhost_resp_cmd[EOM] && tag_ok && (tag == TW'(i));
        end
    end

    // A completion against an empty counter is spurious and reported as stray.
    assign stray_next = dropped || (|(dec & ~inc & cnt_zero));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            rr_ptr     <= '0;
            stray_resp <= 1'b0;
            for (int i = 0; i < N; i++)
                outcnt[i] <= 8'd0;
        end else begin
            stray_resp <= stray_next;
            for (int i = 0; i < N; i++) begin
                if (inc[i] && !dec[i])
                    outcnt[i] <= outcnt[i] + 8'd1;
                else if (dec[i] && !inc[i] && !cnt_zero[i])
                    outcnt[i] <= outcnt[i] - 8'd1;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        if (req_hs && req_eom) begin
                            rr_ptr <= next_ptr;
                        end else begin
                            gnt   <= win;
                            state <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (req_hs && req_eom) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_umi_host_arb.sv
// tb/tb_umi_host_arb.sv - scoreboard bench for umi_host_arb (N=2/MAXOUT=1 and N=3/MAXOUT=2)
module tb_umi_host_arb;
    localparam logic [31:0] CMD_RD     = 32'h0040_0001;
    localparam logic [31:0] CMD_MID    = 32'h0000_0003;
    localparam logic [31:0] CMD_WR_EOM = 32'h0040_0003;
    localparam logic [31:0] RESP_EOM   = 32'h0040_000B;
    localparam logic [63:0] SRC0       = 64'h0000_1111_0000_0001;
    localparam logic [63:0] SRC1       = 64'h0000_2222_0000_0000;
    localparam logic [63:0] SRC0_TAG   = 64'h0000_1111_0000_0000;
    localparam logic [63:0] SRC1_TAG   = 64'h0000_2222_0000_0001;

    typedef struct { logic [63:0] data; logic [63:0] src; } req_exp_t;
    typedef struct { int idx; logic [63:0] data; } resp_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    req_exp_t  exp_req[$];
    resp_exp_t exp_resp[$];

    logic rst_a, rst_b;

    logic [1:0]   a_req_valid, a_req_ready, a_resp_out_valid, a_resp_out_ready;
    logic [63:0]  a_req_cmd;
    logic [127:0] a_req_dst, a_req_src, a_req_data;
    logic [31:0]  a_resp_out_cmd, a_uh_req_cmd, a_uh_resp_cmd;
    logic [63:0]  a_resp_out_dst, a_resp_out_src, a_resp_out_data;
    logic [63:0]  a_uh_req_dst, a_uh_req_src, a_uh_req_data;
    logic [63:0]  a_uh_resp_dst, a_uh_resp_src, a_uh_resp_data;
    logic         a_uh_req_valid, a_uh_req_ready, a_uh_resp_valid, a_uh_resp_ready, a_stray;

    logic [2:0]   b_req_valid, b_req_ready, b_resp_out_valid, b_resp_out_ready;
    logic [95:0]  b_req_cmd;
    logic [191:0] b_req_dst, b_req_src, b_req_data;
    logic [31:0]  b_resp_out_cmd, b_uh_req_cmd, b_uh_resp_cmd;
    logic [63:0]  b_resp_out_dst, b_resp_out_src, b_resp_out_data;
    logic [63:0]  b_uh_req_dst, b_uh_req_src, b_uh_req_data;
    logic [63:0]  b_uh_resp_dst, b_uh_resp_src, b_uh_resp_data;
    logic         b_uh_req_valid, b_uh_req_ready, b_uh_resp_valid, b_uh_resp_ready, b_stray;

    umi_host_arb #(.N(2), .MAXOUT(1)) u0 (
        .clk(clk), .reset(rst_a),
        .req_in_valid(a_req_valid), .req_in_cmd(a_req_cmd), .req_in_dstaddr(a_req_dst),
        .req_in_srcaddr(a_req_src), .req_in_data(a_req_data), .req_in_ready(a_req_ready),
        .resp_out_valid(a_resp_out_valid), .resp_out_cmd(a_resp_out_cmd),
        .resp_out_dstaddr(a_resp_out_dst), .resp_out_srcaddr(a_resp_out_src),
        .resp_out_data(a_resp_out_data), .resp_out_ready(a_resp_out_ready),
        .uhost_req_valid(a_uh_req_valid), .uhost_req_cmd(a_uh_req_cmd),
        .uhost_req_dstaddr(a_uh_req_dst), .uhost_req_srcaddr(a_uh_req_src),
        .uhost_req_data(a_uh_req_data), .uhost_req_ready(a_uh_req_ready),
        .uhost_resp_valid(a_uh_resp_valid), .uhost_resp_cmd(a_uh_resp_cmd),
        .uhost_resp_dstaddr(a_uh_resp_dst), .uhost_resp_srcaddr(a_uh_resp_src),
        .uhost_resp_data(a_uh_resp_data), .uhost_resp_ready(a_uh_resp_ready),
        .stray_resp(a_stray)
    );

    umi_host_arb #(.N(3), .MAXOUT(2)) u1 (
        .clk(clk), .reset(rst_b),
        .req_in_valid(b_req_valid), .req_in_cmd(b_req_cmd), .req_in_dstaddr(b_req_dst),
        .req_in_srcaddr(b_req_src), .req_in_data(b_req_data), .req_in_ready(b_req_ready),
        .resp_out_valid(b_resp_out_valid), .resp_out_cmd(b_resp_out_cmd),
        .resp_out_dstaddr(b_resp_out_dst), .resp_out_srcaddr(b_resp_out_src),
        .resp_out_data(b_resp_out_data), .resp_out_ready(b_resp_out_ready),
        .uhost_req_valid(b_uh_req_valid), .uhost_req_cmd(b_uh_req_cmd),
        .uhost_req_dstaddr(b_uh_req_dst), .uhost_req_srcaddr(b_uh_req_src),
        .uhost_req_data(b_uh_req_data), .uhost_req_ready(b_uh_req_ready),
        .uhost_resp_valid(b_uh_resp_valid), .uhost_resp_cmd(b_uh_resp_cmd),
        .uhost_resp_dstaddr(b_uh_resp_dst), .uhost_resp_srcaddr(b_uh_resp_src),
        .uhost_resp_data(b_uh_resp_data), .uhost_resp_ready(b_uh_resp_ready),
        .stray_resp(b_stray)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input int i, input logic [31:0] c, input logic [63:0] d);
        a_req_cmd[i*32 +: 32]  = c;
        a_req_data[i*64 +: 64] = d;
    endtask

    task automatic a_resp(input logic [63:0] dst, input logic [63:0] d);
        a_uh_resp_valid = 1'b1;
        a_uh_resp_cmd   = RESP_EOM;
        a_uh_resp_dst   = dst;
        a_uh_resp_data  = d;
    endtask

    // Monitor: pops the scoreboard whenever u0 completes a handshake on either side.
    always @(negedge clk) begin
        if (a_uh_req_valid && a_uh_req_ready) begin
            checks++;
            if (exp_req.size() == 0) begin
                failures++;
                $display("FAIL req_unexpected: got data %h expected none", a_uh_req_data);
            end else begin
                req_exp_t e;
                e = exp_req.pop_front();
                if (a_uh_req_data !== e.data || a_uh_req_src !== e.src) begin
                    failures++;
                    $display("FAIL req_beat: got data %h src %h expected data %h src %h",
                             a_uh_req_data, a_uh_req_src, e.data, e.src);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (a_resp_out_valid[i] && a_resp_out_ready[i]) begin
                checks++;
                if (exp_resp.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected: got idx %0d data %h expected none", i, a_resp_out_data);
                end else begin
                    resp_exp_t r;
                    r = exp_resp.pop_front();
                    if (i != r.idx || a_resp_out_data !== r.data) begin
                        failures++;
                        $display("FAIL resp_beat: got idx %0d data %h expected idx %0d data %h",
                                 i, a_resp_out_data, r.idx, r.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_req_valid = 2'b11; a_req_cmd = '0; a_req_dst = '0; a_req_data = '0;
        a_req_src = {SRC1, SRC0};
        a_set(0, CMD_RD, 64'hA0); a_set(1, CMD_RD, 64'hA1);
        a_uh_req_ready = 1'b1; a_resp_out_ready = 2'b11;
        a_uh_resp_src = '0; a_resp(SRC0_TAG, 64'hBAD);
        b_req_valid = '0; b_req_cmd = {3{CMD_RD}}; b_req_dst = '0; b_req_src = '0; b_req_data = '0;
        b_uh_req_ready = 1'b0; b_uh_resp_valid = 1'b0; b_uh_resp_cmd = RESP_EOM;
        b_uh_resp_dst = '0; b_uh_resp_src = '0; b_uh_resp_data = '0; b_resp_out_ready = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_uh_req_valid", a_uh_req_valid, 0);
        chk("rst_req_ready", a_req_ready, 0);
        chk("rst_resp_out_valid", a_resp_out_valid, 0);
        chk("rst_uh_resp_ready", a_uh_resp_ready, 0);
        chk("rst_stray", a_stray, 0);

        // Both requesters stream single-beat reads: 0, 1, then stall on MAXOUT.
        tick(); rst_a = 1'b0; rst_b = 1'b0; a_uh_resp_valid = 1'b0;
        exp_req.push_back('{64'hA0, SRC0_TAG}); exp_req.push_back('{64'hA1, SRC1_TAG});
        @(negedge clk); chk("t1_c0_ready", a_req_ready, 2'b01);
        tick(); @(negedge clk); chk("t1_c1_ready", a_req_ready, 2'b10);
        tick(); @(negedge clk);
        chk("t1_c2_valid", a_uh_req_valid, 0);
        chk("t1_c2_ready", a_req_ready, 2'b00);

        tick(); a_req_valid = 2'b00; a_resp(SRC0_TAG, 64'hB0); exp_resp.push_back('{0, 64'hB0});
        @(negedge clk); chk("r0_valid", a_resp_out_valid, 2'b01);

        // Response to requester 1 held off for two cycles.
        tick(); a_resp(SRC1_TAG, 64'hB1); a_resp_out_ready = 2'b01;
        @(negedge clk); chk("t3_s0_valid", a_resp_out_valid, 2'b10); chk("t3_s0_rdy", a_uh_resp_ready, 0);
        tick(); @(negedge clk); chk("t3_s1_valid", a_resp_out_valid, 2'b10); chk("t3_s1_rdy", a_uh_resp_ready, 0);
        tick(); a_resp_out_ready = 2'b11; exp_resp.push_back('{1, 64'hB1});
        @(negedge clk); chk("t3_s2_valid", a_resp_out_valid, 2'b10); chk("t3_s2_rdy", a_uh_resp_ready, 1);
        chk("t3_cnt1_before", u0.outcnt[1], 1);
        tick(); a_uh_resp_valid = 1'b0;
        @(negedge clk); chk("t3_cnt1_after", u0.outcnt[1], 0);

        // Move rr_ptr to 1 with a lone request from 0, then retire it.
        tick(); a_req_valid = 2'b01; a_set(0, CMD_RD, 64'hA2); exp_req.push_back('{64'hA2, SRC0_TAG});
        tick(); a_req_valid = 2'b00; a_resp(SRC0_TAG, 64'hB2); exp_resp.push_back('{0, 64'hB2});
        tick(); a_uh_resp_valid = 1'b0;
        @(negedge clk); chk("rr_is_1", u0.rr_ptr, 1);

        // Requester 1 3-beat write under toggling ready; requester 0 waits.
        tick(); a_req_valid = 2'b11; a_set(1, CMD_MID, 64'hC1); a_set(0, CMD_RD, 64'hA3);
        a_uh_req_ready = 1'b1; exp_req.push_back('{64'hC1, SRC1_TAG});
        @(negedge clk); chk("t2_c0_ready", a_req_ready, 2'b10);
        tick(); a_set(1, CMD_MID, 64'hC2); a_uh_req_ready = 1'b0;
        @(negedge clk); chk("t2_c1_valid", a_uh_req_valid, 1); chk("t2_c1_ready", a_req_ready, 2'b00);
        chk("t2_c1_data", a_uh_req_data, 64'hC2);
        tick(); a_uh_req_ready = 1'b1; exp_req.push_back('{64'hC2, SRC1_TAG});
        @(negedge clk); chk("t2_c2_ready", a_req_ready, 2'b10);
        tick(); a_set(1, CMD_WR_EOM, 64'hC3); a_uh_req_ready = 1'b0;
        @(negedge clk); chk("t2_c3_ready", a_req_ready, 2'b00);
        tick(); a_uh_req_ready = 1'b1; exp_req.push_back('{64'hC3, SRC1_TAG});
        tick(); a_req_valid = 2'b01; exp_req.push_back('{64'hA3, SRC0_TAG});
        @(negedge clk); chk("t2_rr_after", u0.rr_ptr, 0); chk("t2_c5_ready", a_req_ready, 2'b01);
        tick(); a_req_valid = 2'b00; a_resp(SRC0_TAG, 64'hB3); exp_resp.push_back('{0, 64'hB3});
        tick(); a_uh_resp_valid = 1'b0;

        // Enter LOCK on requester 0, stall, then reset mid-packet.
        tick(); a_req_valid = 2'b01; a_set(0, CMD_MID, 64'hA4); exp_req.push_back('{64'hA4, SRC0_TAG});
        @(negedge clk); chk("t6_first_ready", a_req_ready, 2'b01);
        tick(); a_set(0, CMD_MID, 64'hA5); a_uh_req_ready = 1'b0;
        @(negedge clk); chk("t6_lock_valid", a_uh_req_valid, 1); chk("t6_lock_data", a_uh_req_data, 64'hA5);
        tick(); rst_a = 1'b1;
        @(negedge clk); chk("t6_rst_valid", a_uh_req_valid, 0);
        tick(); rst_a = 1'b0; a_req_valid = 2'b00; a_uh_req_ready = 1'b1;
        @(negedge clk);
        chk("t6_post_valid", a_uh_req_valid, 0); chk("t6_post_rr", u0.rr_ptr, 0);
        chk("t6_post_cnt0", u0.outcnt[0], 0); chk("t6_post_cnt1", u0.outcnt[1], 0);
        tick(); a_resp(SRC0_TAG, 64'hB4); exp_resp.push_back('{0, 64'hB4});
        @(negedge clk); chk("t6_resp_valid", a_resp_out_valid, 2'b01); chk("t6_stray_pre", a_stray, 0);
        tick(); a_uh_resp_valid = 1'b0;
        @(negedge clk); chk("t6_stray_pulse", a_stray, 1);
        tick(); @(negedge clk); chk("t6_stray_end", a_stray, 0);

        // N=3: tag 3 names no requester and is dropped.
        tick(); b_uh_resp_valid = 1'b1; b_uh_resp_dst = 64'h3; b_resp_out_ready = 3'b111;
        @(negedge clk); chk("t4_valid", b_resp_out_valid, 3'b000); chk("t4_rdy", b_uh_resp_ready, 1);
        chk("t4_stray_pre", b_stray, 0);
        tick(); b_uh_resp_valid = 1'b0;
        @(negedge clk); chk("t4_stray_pulse", b_stray, 1);
        tick(); @(negedge clk); chk("t4_stray_end", b_stray, 0);

        // MAXOUT=2: simultaneous request and response on requester 0.
        tick(); b_req_valid = 3'b001; b_uh_req_ready = 1'b1;
        @(negedge clk); chk("t5_first_ready", b_req_ready, 3'b001);
        tick(); b_uh_resp_valid = 1'b1; b_uh_resp_dst = 64'h0;
        @(negedge clk); chk("t5_both_req", b_req_ready, 3'b001); chk("t5_both_resp", b_uh_resp_ready, 1);
        chk("t5_both_valid", b_resp_out_valid, 3'b001);
        tick(); b_req_valid = 3'b000; b_uh_resp_valid = 1'b0;
        @(negedge clk); chk("t5_cnt0", u1.outcnt[0], 1);
        tick(); b_req_valid = 3'b100; b_req_src[128 +: 64] = 64'hF;
        @(negedge clk); chk("t5_tag2_src", b_uh_req_src, 64'hE); chk("t5_tag2_ready", b_req_ready, 3'b100);
        tick(); b_req_valid = 3'b001;
        @(negedge clk); chk("t5_fill_ready", b_req_ready, 3'b001);
        tick(); @(negedge clk);
        chk("t5_full_ready", b_req_ready, 3'b000); chk("t5_full_valid", b_uh_req_valid, 0);

        tick(); b_req_valid = 3'b000;
        @(negedge clk);
        chk("req_queue_left", exp_req.size(), 0);
        chk("resp_queue_left", exp_resp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
